// File: rtl/pio_pkg.sv
// Shared register-map addresses and edge-mode encodings for the PIO input block.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Given the value a stable bit is leaving, is this transition one we capture?
  function automatic logic edge_hit(input int mode, input logic old_v);
    case (mode)
      EDGE_RISING:  return !old_v;
      EDGE_FALLING: return old_v;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input pin: SYNC_STAGES-flop synchroniser followed by a saturating
// debounce filter that commits a new stable value after DEBOUNCE_CYCLES edges.
module pio_in_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic init_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The count only advances while below its last value, so it can never wrap.
  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    if (init_i) begin
      stable_d = sync_out;
      cnt_d    = '0;
    end else if (sync_out == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_out;
      cnt_d    = '0;
      accept_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM PIO input port: debounced pins, edge capture with W1C clear,
// interrupt mask and a level interrupt.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int WIN = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int WW  = $clog2(WIN + 1);

  logic [WW-1:0]         win_q, win_d;
  logic                  init;
  logic [DATA_WIDTH-1:0] stable, accept, ec_set;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] ec_q, ec_d;
  logic [31:0]           rd_q, rd_d;
  logic                  wr;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;

  // Stable tracks the synchroniser directly until the pipeline has filled,
  // so pins already high at reset release never register as an edge.
  assign init  = (win_q != WW'(WIN));
  assign win_d = init ? win_q + WW'(1) : win_q;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_pin
    pio_in_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[g]),
      .init_i  (init),
      .stable_o(stable[g]),
      .accept_o(accept[g])
    );
  end

  assign wr = chipselect && !write_n;

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ec_set[i] = accept[i] & edge_hit(EDGE_MODE, stable[i]);
    end

    mask_d = mask_q;
    if (wr && address == ADDR_IRQMASK) mask_d = writedata[DATA_WIDTH-1:0];

    // Clear first, then OR in new captures: a same-edge set survives.
    ec_d = ec_q;
    if (wr && address == ADDR_EDGECAP) ec_d = ec_q & ~writedata[DATA_WIDTH-1:0];
    ec_d = ec_d | ec_set;

    rd_d = '0;
    case (address)
      ADDR_DATA:    rd_d[DATA_WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_d[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_d[DATA_WIDTH-1:0] = ec_q;
      default:      rd_d = '0;
    endcase
  end

  // NOTE: every register, readdata included, clears asynchronously so the
  // outputs drop the moment reset_n falls, even mid-transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      mask_q <= '0;
      ec_q   <= '0;
      rd_q   <= '0;
    end else begin
      win_q  <= win_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(ec_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Four configurations share one bus and pin stream; a history-based reference
// model predicts readdata/irq each cycle into a scoreboard drained by a monitor.
module tb_pio_in_edge_irq;

  localparam int NDUT = 4;
  localparam int CFG_S [NDUT] = '{2, 2, 2, 3};
  localparam int CFG_D [NDUT] = '{1, 4, 1, 2};
  localparam int CFG_M [NDUT] = '{0, 0, 2, 1};

  typedef struct packed {
    logic [NDUT-1:0][31:0] rd;
    logic [NDUT-1:0]       irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [NDUT];
  logic        irq_w [NDUT];

  always #5 clk = ~clk;

  pio_in_edge_irq #(.DATA_WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_w[0]));
  pio_in_edge_irq #(.DATA_WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_w[1]));
  pio_in_edge_irq #(.DATA_WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_w[2]));
  pio_in_edge_irq #(.DATA_WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_MODE(1)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[3]), .irq(irq_w[3]));

  int checks = 0;
  int errors = 0;

  // Reference model: n counts edges since reset release, hist[n] is the pin
  // value sampled at edge n, m_last is the edge of the latest stable update.
  logic [3:0] hist[$];
  int         n;
  logic [3:0] m_stable [NDUT];
  logic [3:0] m_ec     [NDUT];
  logic [3:0] m_mask   [NDUT];
  int         m_last   [NDUT][4];
  exp_t       sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist.delete();
    hist.push_back(4'h0);
    for (int i = 0; i < NDUT; i++) begin
      m_stable[i] = '0;
      m_ec[i]     = '0;
      m_mask[i]   = '0;
      for (int b = 0; b < 4; b++) m_last[i][b] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] in_v, input logic [1:0] a, input logic wr,
                            input logic [31:0] wd, output exp_t e);
    n++;
    hist.push_back(in_v);
    for (int i = 0; i < NDUT; i++) begin
      int s;
      int d;
      logic [3:0] setb;
      logic [3:0] syncv;
      s = CFG_S[i];
      d = CFG_D[i];
      case (a)
        2'd0:    e.rd[i] = {28'h0, m_stable[i]};
        2'd2:    e.rd[i] = {28'h0, m_mask[i]};
        2'd3:    e.rd[i] = {28'h0, m_ec[i]};
        default: e.rd[i] = 32'h0;
      endcase
      syncv = (n - s >= 1) ? hist[n - s] : 4'h0;
      setb  = '0;
      if (n <= s + d) begin
        m_stable[i] = syncv;
        for (int b = 0; b < 4; b++) m_last[i][b] = n;
      end else begin
        for (int b = 0; b < 4; b++) begin
          logic flip;
          logic nv;
          // Accept when the last d pin samples seen since the previous update
          // all disagree with the stable value.
          flip = 1'b1;
          for (int j = n - d + 1; j <= n; j++)
            if (j <= m_last[i][b] || hist[j - s][b] == m_stable[i][b]) flip = 1'b0;
          if (flip) begin
            nv = ~m_stable[i][b];
            case (CFG_M[i])
              0:       setb[b] = nv;
              1:       setb[b] = ~nv;
              default: setb[b] = 1'b1;
            endcase
            m_stable[i][b] = nv;
            m_last[i][b]   = n;
          end
        end
      end
      if (wr && a == 2'd3) m_ec[i] = m_ec[i] & ~wd[3:0];
      m_ec[i] = m_ec[i] | setb;
      if (wr && a == 2'd2) m_mask[i] = wd[3:0];
      e.irq[i] = |(m_ec[i] & m_mask[i]);
    end
  endtask

  task automatic step(input logic [3:0] in_v, input logic [1:0] a, input logic wr,
                      input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    reset_n = 1'b1;
    in_port = in_v;
    address = a;
    if (wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = wd;
    end else begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
      writedata  = $urandom;
    end
    model_edge(in_v, a, wr, wd, e);
    sb.push_back(e);
  endtask

  task automatic rst_step(input logic [3:0] in_v);
    logic was_high;
    @(negedge clk);
    was_high   = reset_n;
    reset_n    = 1'b0;
    in_port    = in_v;
    address    = 2'($urandom_range(0, 3));
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = $urandom;
    model_reset();
    sb.push_back('0);
    if (was_high) begin
      #1;
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("u%0d_async_reset_readdata", i), rd[i], 32'h0);
        check($sformatf("u%0d_async_reset_irq", i), 32'(irq_w[i]), 32'h0);
      end
    end
  endtask

  task automatic idle(input logic [3:0] v, input logic [1:0] a, input int cnt);
    repeat (cnt) step(v, a, 1'b0, 32'h0);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("u%0d_readdata", i), rd[i], e.rd[i]);
          check($sformatf("u%0d_irq", i), 32'(irq_w[i]), 32'(e.irq[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    int hold;
    logic [3:0] cur;
    reset_n    = 1'b0;
    in_port    = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();

    // Change before edge 10 -> stable at 12, visible on the bus at 13.
    rst_step(4'h0);
    rst_step(4'h0);
    idle(4'h0, 2'd0, 9);
    idle(4'h5, 2'd0, 3);
    peek();
    check("u0_data_latency_edge", rd[0], 32'h0);
    step(4'h5, 2'd0, 1'b0, 32'h0);
    peek();
    check("u0_data_after_change", rd[0], 32'h5);
    step(4'h5, 2'd3, 1'b0, 32'h0);
    peek();
    check("u0_edgecap_after_change", rd[0], 32'h5);

    // Mask, interrupt, W1C clear and set-beats-clear on bit 2.
    step(4'h5, 2'd3, 1'b1, 32'hF);
    step(4'h5, 2'd2, 1'b1, 32'h4);
    peek();
    check("u0_irq_masked_clear", 32'(irq_w[0]), 32'h0);
    idle(4'h1, 2'd0, 2);
    idle(4'h5, 2'd0, 3);
    peek();
    check("u0_irq_on_rise", 32'(irq_w[0]), 32'h1);
    step(4'h5, 2'd3, 1'b1, 32'h4);
    peek();
    check("u0_irq_after_w1c", 32'(irq_w[0]), 32'h0);
    idle(4'h1, 2'd0, 3);
    idle(4'h5, 2'd0, 2);
    step(4'h5, 2'd3, 1'b1, 32'h4);
    peek();
    check("u0_set_beats_clear_irq", 32'(irq_w[0]), 32'h1);
    step(4'h5, 2'd3, 1'b0, 32'h0);
    peek();
    check("u0_set_beats_clear_ec", rd[0], 32'h4);

    // Debounce of 4: a 3-cycle glitch is rejected, a 4-cycle hold is taken.
    rst_step(4'h0);
    rst_step(4'h0);
    idle(4'h0, 2'd0, 10);
    idle(4'h1, 2'd0, 3);
    idle(4'h0, 2'd3, 8);
    peek();
    check("u1_glitch_rejected", rd[1], 32'h0);
    step(4'h1, 2'd3, 1'b0, 32'h0);
    k = n;
    while (n < k + 5) step(4'h1, 2'd3, 1'b0, 32'h0);
    peek();
    check("u1_not_before_latency", rd[1], 32'h0);
    step(4'h1, 2'd3, 1'b0, 32'h0);
    peek();
    check("u1_capture_at_latency", rd[1], 32'h1);

    // Any-edge mode captures both directions on bit 0.
    rst_step(4'h0);
    rst_step(4'h0);
    idle(4'h0, 2'd0, 6);
    idle(4'h1, 2'd3, 4);
    peek();
    check("u2_rise_captured", rd[2], 32'h1);
    step(4'h1, 2'd3, 1'b1, 32'h1);
    idle(4'h0, 2'd3, 4);
    peek();
    check("u2_fall_captured", rd[2], 32'h1);
    check("u0_fall_ignored", rd[0], 32'h0);

    // Pins high through reset release produce no capture; then reset mid-debounce.
    rst_step(4'hF);
    rst_step(4'hF);
    idle(4'hF, 2'd3, 12);
    peek();
    for (int i = 0; i < NDUT; i++) check($sformatf("u%0d_no_capture_at_release", i), rd[i], 32'h0);
    step(4'hF, 2'd0, 1'b0, 32'h0);
    peek();
    check("u0_data_high_at_release", rd[0], 32'hF);
    check("u3_data_high_at_release", rd[3], 32'hF);
    step(4'hF, 2'd2, 1'b1, 32'hF);
    idle(4'h0, 2'd0, 6);
    peek();
    check("u2_irq_on_fall", 32'(irq_w[2]), 32'h1);
    check("u3_irq_on_fall", 32'(irq_w[3]), 32'h1);
    idle(4'hF, 2'd3, 2);
    rst_step(4'hF);
    rst_step(4'h0);

    // Randomised traffic with held pin values and occasional resets.
    hold = 0;
    cur  = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 3)) rst_step(4'($urandom));
      end else begin
        int op;
        if (hold == 0) begin
          cur  = 4'($urandom);
          hold = $urandom_range(1, 7);
        end
        hold--;
        op = $urandom_range(0, 7);
        case (op)
          0:       step(cur, 2'd2, 1'b1, $urandom);
          1:       step(cur, 2'd3, 1'b1, $urandom);
          2:       step(cur, 2'($urandom_range(0, 1)), 1'b1, $urandom);
          default: step(cur, 2'($urandom_range(0, 3)), 1'b0, 32'h0);
        endcase
      end
    end

    peek();
    peek();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
